// File: rtl/shift_controller.sv
`default_nettype none
// ============================================================================
// Module      : shift_controller
// Description : Multicycle sequencer driving the shift-amount mux, the
//               shift-source mux and the shift register, one bit per cycle.
// Revision    : 1.0  initial release
// ============================================================================
module shift_controller #(
    parameter int AMT_W   = 5,
    parameter int LUI_AMT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] shamt_in,
    input  logic [AMT_W-1:0] rs_amt,
    output logic [1:0]       shift_amt_sel,
    output logic             shift_src,
    output logic [2:0]       shift_ctrl,
    output logic [AMT_W-1:0] shift_n,
    output logic             busy,
    output logic             done,
    output logic             reg_write,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] C_OP_ILLEGAL = 3'b111;
    localparam logic [2:0] C_OP_LUI     = 3'b110;
    localparam logic [2:0] C_CTRL_HOLD  = 3'b000;
    localparam logic [2:0] C_CTRL_LOAD  = 3'b001;
    localparam logic [2:0] C_CTRL_SLL   = 3'b010;
    localparam logic [2:0] C_CTRL_SRL   = 3'b011;
    localparam logic [2:0] C_CTRL_SRA   = 3'b100;
    localparam logic [AMT_W-1:0] C_LUI_CNT = AMT_W'(LUI_AMT);
    localparam logic [AMT_W-1:0] C_ONE     = AMT_W'(1);
    localparam logic [AMT_W-1:0] C_ZERO    = '0;

    state_t           r_state;
    logic [AMT_W-1:0] r_cnt;
    logic [2:0]       r_op;

    logic [AMT_W-1:0] w_acc_amt;
    logic [1:0]       w_acc_sel;
    logic [2:0]       w_shift_cmd;

    // Amount source and mux select are decoded from the incoming op at accept.
    always_comb begin
        w_acc_amt = shamt_in;
        w_acc_sel = 2'b00;
        case (op)
            3'b000, 3'b001, 3'b010: begin
                w_acc_amt = shamt_in;
                w_acc_sel = 2'b00;
            end
            3'b011, 3'b100, 3'b101: begin
                w_acc_amt = rs_amt;
                w_acc_sel = 2'b01;
            end
            3'b110: begin
                w_acc_amt = C_LUI_CNT;
                w_acc_sel = 2'b10;
            end
            default: begin
                w_acc_amt = C_ZERO;
                w_acc_sel = 2'b00;
            end
        endcase
    end

    // Per-bit shift command follows the latched op, lui shifts left.
    always_comb begin
        w_shift_cmd = C_CTRL_SLL;
        case (r_op)
            3'b001, 3'b100: w_shift_cmd = C_CTRL_SRL;
            3'b010, 3'b101: w_shift_cmd = C_CTRL_SRA;
            default:        w_shift_cmd = C_CTRL_SLL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= C_ZERO;
            r_op          <= 3'b000;
            shift_amt_sel <= 2'b00;
            shift_src     <= 1'b0;
            shift_ctrl    <= C_CTRL_HOLD;
            shift_n       <= C_ZERO;
            busy          <= 1'b0;
            done          <= 1'b0;
            reg_write     <= 1'b0;
            err           <= 1'b0;
        end else begin
            err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && (op != C_OP_ILLEGAL)) begin
                        r_state       <= ST_LOAD;
                        r_cnt         <= w_acc_amt;
                        r_op          <= op;
                        shift_amt_sel <= w_acc_sel;
                        shift_src     <= (op == C_OP_LUI);
                        shift_ctrl    <= C_CTRL_LOAD;
                        busy          <= 1'b1;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (r_cnt != C_ZERO) begin
                        r_state    <= ST_SHIFT;
                        shift_ctrl <= w_shift_cmd;
                        shift_n    <= C_ONE;
                    end else begin
                        r_state    <= ST_DONE;
                        shift_ctrl <= C_CTRL_HOLD;
                        done       <= 1'b1;
                        reg_write  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != C_ZERO) begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                    // The cycle issuing the last shift sees cnt=1.
                    if (r_cnt <= C_ONE) begin
                        r_state    <= ST_DONE;
                        shift_ctrl <= C_CTRL_HOLD;
                        shift_n    <= C_ZERO;
                        done       <= 1'b1;
                        reg_write  <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_cnt         <= C_ZERO;
                    shift_amt_sel <= 2'b00;
                    shift_src     <= 1'b0;
                    shift_ctrl    <= C_CTRL_HOLD;
                    shift_n       <= C_ZERO;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    reg_write     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_controller
// Description : Directed self-checking bench for shift_controller.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shift_controller;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [4:0] shamt_in;
    logic [4:0] rs_amt;
    logic [1:0] shift_amt_sel;
    logic       shift_src;
    logic [2:0] shift_ctrl;
    logic [4:0] shift_n;
    logic       busy;
    logic       done;
    logic       reg_write;
    logic       err;

    int errors = 0;
    int checks = 0;

    shift_controller #(.AMT_W(5), .LUI_AMT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .op            (op),
        .shamt_in      (shamt_in),
        .rs_amt        (rs_amt),
        .shift_amt_sel (shift_amt_sel),
        .shift_src     (shift_src),
        .shift_ctrl    (shift_ctrl),
        .shift_n       (shift_n),
        .busy          (busy),
        .done          (done),
        .reg_write     (reg_write),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: {amt_sel[1:0], src, ctrl[2:0], shift_n[4:0], busy, done, reg_write, err}
    function automatic logic [14:0] obs();
        return {shift_amt_sel, shift_src, shift_ctrl, shift_n, busy, done, reg_write, err};
    endfunction

    // Expected outputs for cycle c (1 = LOAD) of an operation with n shifts.
    function automatic logic [14:0] exp_vec(input logic [1:0] sel, input logic src,
                                            input logic [2:0] cmd, input int n, input int c);
        logic [2:0] ctrl;
        logic [4:0] sn;
        logic       dn;
        dn   = (c == n + 2);
        ctrl = (c == 1) ? 3'b001 : (dn ? 3'b000 : cmd);
        sn   = (c > 1 && !dn) ? 5'd1 : 5'd0;
        return {sel, src, ctrl, sn, 1'b1, dn, dn, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'b000; shamt_in = 5'd0; rs_amt = 5'd0;
        step(); step();
        checks++;
        if (obs() !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs(), 15'd0);
        end
        reset = 1'b0;
        step();
        checks++;
        if (obs() !== 15'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected %b", obs(), 15'd0);
        end
    endtask

    task automatic test_sll();
        op = 3'b000; shamt_in = 5'd3; start = 1'b1;
        step();
        start = 1'b0; shamt_in = 5'd7;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (obs() !== exp_vec(2'b00, 1'b0, 3'b010, 3, c)) begin
                errors++;
                $display("FAIL sll_cycle%0d: got %b expected %b", c, obs(), exp_vec(2'b00, 1'b0, 3'b010, 3, c));
            end
            step();
        end
        checks++;
        if (obs() !== 15'd0) begin
            errors++;
            $display("FAIL sll_back_idle: got %b expected %b", obs(), 15'd0);
        end
    endtask

    task automatic test_srav_zero();
        op = 3'b101; rs_amt = 5'd0; shamt_in = 5'd9; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (obs() !== exp_vec(2'b01, 1'b0, 3'b100, 0, c)) begin
                errors++;
                $display("FAIL srav0_cycle%0d: got %b expected %b", c, obs(), exp_vec(2'b01, 1'b0, 3'b100, 0, c));
            end
            step();
        end
        checks++;
        if (obs() !== 15'd0) begin
            errors++;
            $display("FAIL srav0_back_idle: got %b expected %b", obs(), 15'd0);
        end
    endtask

    task automatic test_lui();
        op = 3'b110; shamt_in = 5'd2; rs_amt = 5'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            checks++;
            if (obs() !== exp_vec(2'b10, 1'b1, 3'b010, 16, c)) begin
                errors++;
                $display("FAIL lui_cycle%0d: got %b expected %b", c, obs(), exp_vec(2'b10, 1'b1, 3'b010, 16, c));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        // start stays high: DONE must not re-accept, IDLE accepts the next op.
        step();
        op = 3'b010; shamt_in = 5'd31; start = 1'b1;
        step();
        for (int c = 1; c <= 33; c++) begin
            checks++;
            if (obs() !== exp_vec(2'b00, 1'b0, 3'b100, 31, c)) begin
                errors++;
                $display("FAIL sra31_cycle%0d: got %b expected %b", c, obs(), exp_vec(2'b00, 1'b0, 3'b100, 31, c));
            end
            step();
        end
        checks++;
        if (obs() !== 15'd0) begin
            errors++;
            $display("FAIL sra31_idle_gap: got %b expected %b", obs(), 15'd0);
        end
        op = 3'b001; shamt_in = 5'd1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (obs() !== exp_vec(2'b00, 1'b0, 3'b011, 1, c)) begin
                errors++;
                $display("FAIL srl1_cycle%0d: got %b expected %b", c, obs(), exp_vec(2'b00, 1'b0, 3'b011, 1, c));
            end
            step();
        end
    endtask

    task automatic test_illegal();
        op = 3'b111; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (obs() !== 15'b000_0000_0000_0001) begin
            errors++;
            $display("FAIL illegal_err_pulse: got %b expected %b", obs(), 15'b000_0000_0000_0001);
        end
        step();
        checks++;
        if (obs() !== 15'd0) begin
            errors++;
            $display("FAIL illegal_after: got %b expected %b", obs(), 15'd0);
        end
    endtask

    task automatic test_reset_mid();
        op = 3'b001; shamt_in = 5'd8; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (obs() !== exp_vec(2'b00, 1'b0, 3'b011, 8, c)) begin
                errors++;
                $display("FAIL srl8_cycle%0d: got %b expected %b", c, obs(), exp_vec(2'b00, 1'b0, 3'b011, 8, c));
            end
            if (c == 5) reset = 1'b1;
            step();
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs() !== 15'd0) begin
                errors++;
                $display("FAIL abort_quiet%0d: got %b expected %b", k, obs(), 15'd0);
            end
            step();
        end
        op = 3'b100; rs_amt = 5'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (obs() !== exp_vec(2'b01, 1'b0, 3'b011, 2, c)) begin
                errors++;
                $display("FAIL srlv2_cycle%0d: got %b expected %b", c, obs(), exp_vec(2'b01, 1'b0, 3'b011, 2, c));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_sll();
        test_srav_zero();
        test_lui();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
